// File: rtl/common_types.sv
// rtl/common_types.sv - shared bus and state types for the CPU memory port and its initiators
package common_types;

   localparam int ADDR_W = 12;
   localparam int DATA_W = 8;

   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [DATA_W-1:0] data_t;

   typedef enum logic {
      MW_READ  = 1'b0,
      MW_WRITE = 1'b1
   } mw_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_READ,
      ST_WRITE,
      ST_DONE
   } memcopy_state_t;

endpackage

// File: rtl/cpumemcopy.sv
// rtl/cpumemcopy.sv - byte-serial block copy engine acting as cpumemory bus initiator
// Build option MEMCOPY_FILL_EN adds a fill mode (fill, fill_value ports); default build is copy only.
module cpumemcopy
   import common_types::*;
(
   input  logic   clk,
   input  logic   reset_n,
   input  logic   start,
   input  addr_t  src,
   input  addr_t  dst,
   input  addr_t  len,
   output logic   busy,
   output logic   done,
   output mw_t    mw,
   output addr_t  mem_addr,
   output data_t  mem_wdata,
   input  data_t  mem_rdata
`ifdef MEMCOPY_FILL_EN
   ,
   input  logic   fill,
   input  data_t  fill_value
`endif
);

   memcopy_state_t state, state_nxt;
   addr_t          src_ptr, dst_ptr, remaining;
   logic           fill_mode;
   logic           start_fill;
   data_t          fill_byte;

`ifdef MEMCOPY_FILL_EN
   assign start_fill = fill;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         fill_mode <= 1'b0;
         fill_byte <= '0;
      end else if (state == ST_IDLE && start) begin
         fill_mode <= fill;
         fill_byte <= fill_value;
      end
   end
`else
   assign start_fill = 1'b0;
   assign fill_mode  = 1'b0;
   assign fill_byte  = '0;
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         src_ptr   <= '0;
         dst_ptr   <= '0;
         remaining <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  src_ptr   <= src;
                  dst_ptr   <= dst;
                  remaining <= len;
               end
            end
            // Pointers wrap naturally at the address width.
            ST_WRITE: begin
               src_ptr   <= src_ptr + addr_t'(1);
               dst_ptr   <= dst_ptr + addr_t'(1);
               remaining <= remaining - addr_t'(1);
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      mw        = MW_READ;
      mem_addr  = '0;
      mem_wdata = '0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               if (len == '0)
                  state_nxt = ST_DONE;
               else if (start_fill)
                  state_nxt = ST_WRITE;
               else
                  state_nxt = ST_READ;
            end
         end
         ST_READ: begin
            busy      = 1'b1;
            mem_addr  = src_ptr;
            state_nxt = ST_WRITE;
         end
         ST_WRITE: begin
            busy      = 1'b1;
            mw        = MW_WRITE;
            mem_addr  = dst_ptr;
            mem_wdata = fill_mode ? fill_byte : mem_rdata;
            // Decision uses the count before this write's decrement.
            if (remaining == addr_t'(1))
               state_nxt = ST_DONE;
            else if (fill_mode)
               state_nxt = ST_WRITE;
            else
               state_nxt = ST_READ;
         end
         ST_DONE: begin
            done      = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_cpumemcopy.sv
// tb/tb_cpumemcopy.sv - directed self-checking bench for cpumemcopy with a registered-read memory model
module tb_cpumemcopy;
   import common_types::*;

   logic  clk = 1'b0;
   logic  reset_n = 1'b0;
   logic  start = 1'b0;
   addr_t src = '0, dst = '0, len = '0;
   logic  busy, done;
   mw_t   mw;
   addr_t mem_addr;
   data_t mem_wdata, mem_rdata;
`ifdef MEMCOPY_FILL_EN
   logic  fill = 1'b0;
   data_t fill_value = '0;
`endif

   int checks = 0;
   int errors = 0;

   data_t mem [0:4095];
   data_t exp_b [4];

   always #5 clk = ~clk;

   cpumemcopy dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .src        (src),
      .dst        (dst),
      .len        (len),
      .busy       (busy),
      .done       (done),
      .mw         (mw),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
`ifdef MEMCOPY_FILL_EN
      ,
      .fill       (fill),
      .fill_value (fill_value)
`endif
   );

   // cpumemory stand-in: registered read, data_out held during writes
   always @(posedge clk) begin
      if (mw == MW_WRITE)
         mem[mem_addr] <= mem_wdata;
      else
         mem_rdata <= mem[mem_addr];
   end

   task automatic issue_start(input addr_t s, input addr_t d, input addr_t l);
      @(negedge clk);
      start = 1'b1;
      src   = s;
      dst   = d;
      len   = l;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      for (int j = 0; j < 5; j++) begin
         @(negedge clk);
         checks++;
         if ({mw, mem_addr, mem_wdata, busy, done} !== {MW_READ, 12'h000, 8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_idle cyc%0d got mw=%0d addr=%h wdata=%h busy=%b done=%b required mw=0 addr=000 wdata=00 busy=0 done=0",
                     j, mw, mem_addr, mem_wdata, busy, done);
         end
      end
   endtask

   task automatic test_copy4;
      mw_t   e_mw;
      addr_t e_addr;
      logic  e_busy, e_done;
      issue_start(12'h010, 12'h100, 12'd4);
      for (int j = 1; j <= 10; j++) begin
         @(negedge clk);
         e_mw = MW_READ; e_addr = 12'h000; e_busy = 1'b0; e_done = 1'b0;
         if (j <= 8 && (j % 2) == 1) begin
            e_addr = addr_t'(12'h010 + (j - 1) / 2); e_busy = 1'b1;
         end else if (j <= 8) begin
            e_mw = MW_WRITE; e_addr = addr_t'(12'h100 + j / 2 - 1); e_busy = 1'b1;
         end else if (j == 9) begin
            e_done = 1'b1;
         end
         checks++;
         if ({mw, mem_addr, busy, done} !== {e_mw, e_addr, e_busy, e_done}) begin
            errors++;
            $display("FAIL copy4_cycle k+%0d got mw=%0d addr=%h busy=%b done=%b required mw=%0d addr=%h busy=%b done=%b",
                     j, mw, mem_addr, busy, done, e_mw, e_addr, e_busy, e_done);
         end
         if (e_mw == MW_WRITE) begin
            checks++;
            if (mem_wdata !== exp_b[j / 2 - 1]) begin
               errors++;
               $display("FAIL copy4_wdata k+%0d got %h required %h", j, mem_wdata, exp_b[j / 2 - 1]);
            end
         end
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (mem[12'h100 + i] !== exp_b[i]) begin
            errors++;
            $display("FAIL copy4_mem[%h] got %h required %h", 12'h100 + i, mem[12'h100 + i], exp_b[i]);
         end
      end
   endtask

   task automatic test_len0;
      issue_start(12'h010, 12'h300, 12'd0);
      for (int j = 1; j <= 3; j++) begin
         @(negedge clk);
         checks++;
         if ({mw, busy, done} !== {MW_READ, 1'b0, (j == 1)}) begin
            errors++;
            $display("FAIL len0_cycle k+%0d got mw=%0d busy=%b done=%b required mw=0 busy=0 done=%b",
                     j, mw, busy, done, (j == 1));
         end
      end
      checks++;
      if (mem[12'h300] !== 8'h0B) begin
         errors++;
         $display("FAIL len0_mem got %h required 0b", mem[12'h300]);
      end
   endtask

   task automatic test_overlap;
      int done_cyc;
      done_cyc = -1;
      @(negedge clk);
      mem[12'h020] = 8'hAA;
      issue_start(12'h020, 12'h021, 12'd3);
      for (int j = 1; j <= 9; j++) begin
         @(negedge clk);
         if (done === 1'b1 && done_cyc < 0) done_cyc = j;
      end
      checks++;
      if (done_cyc != 7) begin
         errors++;
         $display("FAIL overlap_done_cycle got k+%0d required k+7", done_cyc);
      end
      for (int i = 1; i <= 3; i++) begin
         checks++;
         if (mem[12'h020 + i] !== 8'hAA) begin
            errors++;
            $display("FAIL overlap_mem[%h] got %h required aa", 12'h020 + i, mem[12'h020 + i]);
         end
      end
   endtask

   task automatic test_wrap;
      issue_start(12'hFFF, 12'h400, 12'd2);
      for (int j = 1; j <= 6; j++) begin
         @(negedge clk);
         if (j == 3) begin
            checks++;
            if ({mw, mem_addr} !== {MW_READ, 12'h000}) begin
               errors++;
               $display("FAIL wrap_src_ptr got mw=%0d addr=%h required mw=0 addr=000", mw, mem_addr);
            end
         end
         if (j == 5) begin
            checks++;
            if (done !== 1'b1) begin
               errors++;
               $display("FAIL wrap_done got %b required 1", done);
            end
         end
      end
      checks++;
      if ({mem[12'h400], mem[12'h401]} !== 16'hE60B) begin
         errors++;
         $display("FAIL wrap_mem got %h%h required e60b", mem[12'h400], mem[12'h401]);
      end
   endtask

   task automatic test_abort;
      int seen_done;
      seen_done = 0;
      issue_start(12'h010, 12'h180, 12'd4);
      @(negedge clk);
      start = 1'b1; src = 12'h050; dst = 12'h1C0; len = 12'd1;
      @(negedge clk);
      checks++;
      if ({mw, mem_addr} !== {MW_WRITE, 12'h180}) begin
         errors++;
         $display("FAIL abort_write0 got mw=%0d addr=%h required mw=1 addr=180", mw, mem_addr);
      end
      start = 1'b0;
      @(negedge clk);
      checks++;
      if ({mw, mem_addr, busy} !== {MW_READ, 12'h011, 1'b1}) begin
         errors++;
         $display("FAIL abort_start_ignored got mw=%0d addr=%h busy=%b required mw=0 addr=011 busy=1", mw, mem_addr, busy);
      end
      reset_n = 1'b0;
      @(negedge clk);
      checks++;
      if ({mw, mem_addr, mem_wdata, busy, done} !== {MW_READ, 12'h000, 8'h00, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL abort_reset_idle got mw=%0d addr=%h wdata=%h busy=%b done=%b required idle values",
                  mw, mem_addr, mem_wdata, busy, done);
      end
      reset_n = 1'b1;
      for (int j = 0; j < 12; j++) begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0) seen_done++;
      end
      checks++;
      if (seen_done != 0) begin
         errors++;
         $display("FAIL abort_quiet got %0d active cycles required 0", seen_done);
      end
      checks++;
      if ({mem[12'h180], mem[12'h181], mem[12'h1C0]} !== 24'h5BB0CB) begin
         errors++;
         $display("FAIL abort_mem got %h %h %h required 5b b0 cb", mem[12'h180], mem[12'h181], mem[12'h1C0]);
      end
   endtask

`ifdef MEMCOPY_FILL_EN
   task automatic test_fill;
      fill = 1'b1;
      fill_value = 8'h5C;
      issue_start(12'h010, 12'h200, 12'd3);
      fill = 1'b0;
      fill_value = 8'h00;
      for (int j = 1; j <= 5; j++) begin
         @(negedge clk);
         checks++;
         if (j <= 3) begin
            if ({mw, mem_addr, mem_wdata, busy, done} !== {MW_WRITE, addr_t'(12'h200 + j - 1), 8'h5C, 1'b1, 1'b0}) begin
               errors++;
               $display("FAIL fill_write k+%0d got mw=%0d addr=%h wdata=%h busy=%b done=%b", j, mw, mem_addr, mem_wdata, busy, done);
            end
         end else if ({mw, busy, done} !== {MW_READ, 1'b0, (j == 4)}) begin
            errors++;
            $display("FAIL fill_end k+%0d got mw=%0d busy=%b done=%b required done=%b", j, mw, busy, done, (j == 4));
         end
      end
      checks++;
      if ({mem[12'h200], mem[12'h201], mem[12'h202]} !== 24'h5C5C5C) begin
         errors++;
         $display("FAIL fill_mem got %h %h %h required 5c 5c 5c", mem[12'h200], mem[12'h201], mem[12'h202]);
      end
   endtask
`endif

   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = 8'(i * 37 + 11);
      exp_b[0] = 8'h5B; exp_b[1] = 8'h80; exp_b[2] = 8'hA5; exp_b[3] = 8'hCA;
      test_reset;
      test_copy4;
      test_len0;
      test_overlap;
      test_wrap;
      test_abort;
`ifdef MEMCOPY_FILL_EN
      test_fill;
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
